// File: rtl/dut_master.sv
// Bus initiator: pushes (a, b) pairs into the DUT A/B FIFOs and returns each y result.
// Define DUT_MASTER_POLL_EN to poll FIFO status before every access.
module dut_master #(
    parameter int unsigned POLL_LIMIT = 255,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             op_valid,
    input  logic             op_a,
    input  logic             op_b,
    output logic             op_ready,
    output logic             res_valid,
    output logic             res_data,
    input  logic             res_ready,
    output logic [2:0]       write_address,
    output logic             write_data,
    output logic             write_en,
    input  logic             write_rdy,
    output logic [2:0]       read_address,
    output logic             read_en,
    input  logic             read_data,
    input  logic             read_rdy,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err
);

    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPollA,
        StWrA,
        StPollB,
        StWrB,
        StPollY,
        StRdY,
        StOut
    } state_t;

`ifdef DUT_MASTER_POLL_EN
    localparam state_t AfterIdle = StPollA;
    localparam state_t AfterWrA  = StPollB;
    localparam state_t AfterWrB  = StPollY;
`else
    localparam state_t AfterIdle = StWrA;
    localparam state_t AfterWrA  = StWrB;
    localparam state_t AfterWrB  = StRdY;
`endif

    state_t            state_q, state_d;
    logic              a_q, b_q;
    logic              res_data_q;
    logic [CNT_W-1:0]  done_cnt_q;
    logic              err_q;
    logic [PW-1:0]     poll_cnt_q;

    logic wr_state, rd_state, waiting, leave, timeout;

    // Bus decode: address and data depend only on the state, so they hold for its whole length.
    always_comb begin
        wr_state      = 1'b0;
        rd_state      = 1'b0;
        write_address = 3'd0;
        write_data    = 1'b0;
        read_address  = 3'd0;
        unique case (state_q)
            StPollA: begin
                rd_state     = 1'b1;
                read_address = 3'd0;
            end
            StPollB: begin
                rd_state     = 1'b1;
                read_address = 3'd1;
            end
            StPollY: begin
                rd_state     = 1'b1;
                read_address = 3'd2;
            end
            StRdY: begin
                rd_state     = 1'b1;
                read_address = 3'd3;
            end
            StWrA: begin
                wr_state      = 1'b1;
                write_address = 3'd4;
                write_data    = a_q;
            end
            StWrB: begin
                wr_state      = 1'b1;
                write_address = 3'd5;
                write_data    = b_q;
            end
            default: ;
        endcase
    end

    assign write_en  = wr_state & write_rdy;
    assign read_en   = rd_state & read_rdy;
    assign op_ready  = (state_q == StIdle);
    assign res_valid = (state_q == StOut);
    assign res_data  = res_data_q;
    assign done_cnt  = done_cnt_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (op_valid)             state_d = AfterIdle;
            StPollA: if (read_en && read_data) state_d = StWrA;
            StWrA:   if (write_en)             state_d = AfterWrA;
            StPollB: if (read_en && read_data) state_d = StWrB;
            StWrB:   if (write_en)             state_d = AfterWrB;
            StPollY: if (read_en && read_data) state_d = StRdY;
            StRdY:   if (read_en)              state_d = StOut;
            StOut:   if (res_ready)            state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    // Every non-advancing bus cycle counts toward the timeout, rdy-low cycles included.
    assign waiting = wr_state | rd_state;
    assign leave   = (state_d != state_q);
    assign timeout = waiting & ~leave & (poll_cnt_q == PW'(POLL_LIMIT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            res_data_q <= 1'b0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
            poll_cnt_q <= '0;
        end else begin
            if (timeout) begin
                state_q    <= StIdle;
                err_q      <= 1'b1;
                poll_cnt_q <= '0;
            end else begin
                state_q <= state_d;
                if (leave || !waiting) begin
                    poll_cnt_q <= '0;
                end else begin
                    poll_cnt_q <= poll_cnt_q + PW'(1);
                end
            end
            if (state_q == StIdle && op_valid) begin
                a_q <= op_a;
                b_q <= op_b;
            end
            if (state_q == StRdY && read_en) begin
                res_data_q <= read_data;
            end
            if (state_q == StOut && res_ready) begin
                done_cnt_q <= done_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/dut_master.md
Name: dut_master

Overview:
- Bus initiator that drives the DUT's write/read method interface from the master side.
- Accepts (a, b) operand pairs on a valid/ready stream and writes them into the DUT A and B FIFOs.
- Retrieves each y result from the DUT and presents it on a valid/ready result stream.
- Sits between a testbench or stimulus source and dut, in place of direct bench pokes.

Parameters:
- POLL_LIMIT, 255: maximum consecutive unsuccessful status polls or rdy-low cycles per phase before timeout.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- op_valid  input  1  operand pair valid.
- op_a  input  1  operand for DUT FIFO A.
- op_b  input  1  operand for DUT FIFO B.
- op_ready  output  1  master can accept an operand pair.
- res_valid  output  1  result valid.
- res_data  output  1  y value read from the DUT.
- res_ready  input  1  consumer accepts the result.
- write_address  output  3  DUT write address.
- write_data  output  1  DUT write data.
- write_en  output  1  DUT write enable.
- write_rdy  input  1  DUT write ready.
- read_address  output  3  DUT read address.
- read_en  output  1  DUT read enable.
- read_data  input  1  DUT read data; valid in the same cycle as read_en.
- read_rdy  input  1  DUT read ready.
- done_cnt  output  CNT_W  count of completed transactions; wraps.
- err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; all outputs 0 except op_ready=1.
  - done_cnt=0, err=0, poll counter=0.
  - Reset mid-transaction abandons it with no result; write_en/read_en deassert immediately.
- DUT address map:
  - read 0 = A FIFO full_n; read 1 = B FIFO full_n; read 2 = Y FIFO empty_n; read 3 = Y data.
  - write 4 = A data; write 5 = B data.
- Bus rules:
  - write_en = (state is a write state) & write_rdy. read_en = (state is a read state) & read_rdy.
  - Enables are never asserted while the matching rdy is low.
  - A write commits in a cycle with write_en=1. A read completes in a cycle with read_en=1; read_data is sampled on that edge.
  - Address and write_data are held stable for the whole state.
- FSM states: IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, OUT.
  - IDLE: op_ready=1. On op_valid&op_ready, latch op_a and op_b, go to POLL_A.
  - POLL_A / POLL_B / POLL_Y: read addr 0 / 1 / 2. read_data=1 -> WR_A / WR_B / RD_Y next cycle; else stay.
  - WR_A: write addr 4, data=latched a; on commit -> POLL_B.
  - WR_B: write addr 5, data=latched b; on commit -> POLL_Y.
  - RD_Y: read addr 3; on completion register read_data into res_data -> OUT.
  - OUT: res_valid=1, res_data held. On res_ready -> IDLE and done_cnt+1 (same edge).
  - Minimum latency from op accept to res_valid is 6 cycles (one cycle per state, all polls succeeding first time).
- Poll counter:
  - Cleared on every state change.
  - Increments each cycle in a POLL or WR/RD state that does not advance, including cycles where rdy=0.
  - Reaching POLL_LIMIT: err<=1, state -> IDLE, operation dropped, no res_valid, done_cnt unchanged.
- err is sticky until reset; the master keeps accepting operations after err is set.
- op_ready=0 in every state except IDLE; back-to-back operations need one IDLE cycle.
- done_cnt wraps from 2^CNT_W-1 to 0.
- res_ready held high before OUT has no effect.

Optional Feature:
- Macro: DUT_MASTER_POLL_EN.
- Defined: behaviour as above, with status polling before each access.
- Undefined:
  - POLL_A, POLL_B and POLL_Y are removed. IDLE -> WR_A -> WR_B -> RD_Y -> OUT.
  - Flow control relies only on write_rdy/read_rdy.
  - The timeout still applies to rdy-low cycles in WR and RD states.
  - Minimum latency is 3 cycles.

Test Plan:
- Reset mid-WR_B (RST_N low 2 cycles) -> all enables 0 and op_ready=1 asynchronously; done_cnt=0; no res_valid afterwards.
- op_a=1, op_b=0; DUT model returns y=a|b and all status reads 1 -> write 4 data 1, then write 5 data 0, then read 3; res_data=1 exactly 6 cycles after accept (3 with macro off); done_cnt=1.
- Read 0 returns 0 for 10 cycles, then 1 -> master stays in POLL_A 10 cycles with read_address=0; transaction completes; err=0.
- write_rdy low permanently with POLL_LIMIT=8 -> err=1 after 8 stalled cycles; state IDLE; no result; a following op with rdy restored completes with err still 1.
- res_ready held low 5 cycles in OUT -> res_valid and res_data stable, op_ready=0 throughout; done_cnt increments only on the accept edge.
- CNT_W=2, 5 back-to-back ops with a|b pattern (0,0)(0,1)(1,0)(1,1)(0,0) -> results 0,1,1,1,0; done_cnt sequence 1,2,3,0,1.
